// File: rtl/plru_set_array.sv
`default_nettype none
// ============================================================================
//  Module      : plru_set_array
//  Description : Per-set tree pseudo-LRU state store. Keeps ASSOC-1 heap-ordered
//                tree bits for each of SETS sets, updates them on access
//                (way becomes MRU) and invalidate (way becomes next victim),
//                and returns a registered victim way for a queried set.
//  Ports       : clk, rst (sync, active high)
//                acc_valid/acc_set/acc_way  - hit/fill update
//                inv_valid/inv_set/inv_way  - invalidate update
//                vic_req/vic_set            - victim query
//                vic_valid/vic_way/vic_bits - registered query result
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_set_array #(
    parameter int ASSOC = 8,
    parameter int SETS  = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   acc_valid,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] acc_set,
    input  logic [$clog2(ASSOC)-1:0]               acc_way,
    input  logic                                   inv_valid,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] inv_set,
    input  logic [$clog2(ASSOC)-1:0]               inv_way,
    input  logic                                   vic_req,
    input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0] vic_set,
    output logic                                   vic_valid,
    output logic [$clog2(ASSOC)-1:0]               vic_way,
    output logic [ASSOC-2:0]                       vic_bits
);

    localparam int LW = $clog2(ASSOC);
    localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int NB = ASSOC - 1;

    if ((ASSOC < 2) || ((ASSOC & (ASSOC - 1)) != 0)) begin : g_bad_assoc
        $error("plru_set_array: ASSOC must be a power of two >= 2");
    end
    if ((SETS < 1) || ((SETS & (SETS - 1)) != 0)) begin : g_bad_sets
        $error("plru_set_array: SETS must be a power of two >= 1");
    end

    typedef logic [NB-1:0] tree_t;

    tree_t            r_tree [SETS];
    logic             r_vic_valid;
    logic [LW-1:0]    r_vic_way;
    tree_t            r_vic_bits;

    logic [SW-1:0]    w_acc_idx;
    logic [SW-1:0]    w_inv_idx;
    logic [SW-1:0]    w_vic_idx;
    logic             w_acc_drop;
    tree_t            w_vic_fwd;

    // Walk the path for 'way' (MSB first) and overwrite each path node with
    // the way bit, or its inverse for an invalidate. Off-path nodes untouched.
    function automatic tree_t f_update(input tree_t bits, input logic [LW-1:0] way,
                                       input logic inv);
        tree_t         t;
        logic [LW-1:0] w;
        logic          b;
        int            n;
        t = bits;
        w = way;
        n = 0;
        for (int k = 0; k < LW; k++) begin
            b            = w[LW-1];
            t[n[LW-1:0]] = b ^ inv;
            n            = 2 * n + 1 + int'(b);
            w            = w << 1;
        end
        return t;
    endfunction

    // Follow the tree away from the MRU side: bit 1 -> left (0), bit 0 -> right (1).
    function automatic logic [LW-1:0] f_victim(input tree_t bits);
        logic [LW-1:0] v;
        logic          d;
        int            n;
        v = '0;
        n = 0;
        for (int k = 0; k < LW; k++) begin
            d    = ~bits[n[LW-1:0]];
            v    = v << 1;
            v[0] = d;
            n    = 2 * n + 1 + int'(d);
        end
        return v;
    endfunction

    // A single-set array ignores the set index entirely.
    if (SETS == 1) begin : g_one_set
        assign w_acc_idx = '0;
        assign w_inv_idx = '0;
        assign w_vic_idx = '0;
    end else begin : g_many_sets
        assign w_acc_idx = acc_set;
        assign w_inv_idx = inv_set;
        assign w_vic_idx = vic_set;
    end

    // Invalidate has priority when both target the same set.
    assign w_acc_drop = inv_valid && (w_inv_idx == w_acc_idx);

    // Victim query sees the state as written at this same edge.
    always_comb begin
        w_vic_fwd = r_tree[w_vic_idx];
        if (inv_valid && (w_inv_idx == w_vic_idx)) begin
            w_vic_fwd = f_update(r_tree[w_vic_idx], inv_way, 1'b1);
        end else if (acc_valid && (w_acc_idx == w_vic_idx)) begin
            w_vic_fwd = f_update(r_tree[w_vic_idx], acc_way, 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_tree[s] <= '0;
            end
            r_vic_valid <= 1'b0;
            r_vic_way   <= '0;
            r_vic_bits  <= '0;
        end else begin
            if (acc_valid && !w_acc_drop) begin
                r_tree[w_acc_idx] <= f_update(r_tree[w_acc_idx], acc_way, 1'b0);
            end
            if (inv_valid) begin
                r_tree[w_inv_idx] <= f_update(r_tree[w_inv_idx], inv_way, 1'b1);
            end
            r_vic_valid <= vic_req;
            if (vic_req) begin
                r_vic_way  <= f_victim(w_vic_fwd);
                r_vic_bits <= w_vic_fwd;
            end
        end
    end

    assign vic_valid = r_vic_valid;
    assign vic_way   = r_vic_way;
    assign vic_bits  = r_vic_bits;

endmodule
`default_nettype wire

// File: tb/tb_plru_set_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plru_set_array
//  Description : Self-checking bench for plru_set_array. Instance A uses
//                ASSOC=8/SETS=64, instance B uses ASSOC=2/SETS=1. A behavioural
//                model predicts every output; literal checks pin key values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plru_set_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: 8 ways, 64 sets
    logic       a_acc_valid, a_inv_valid, a_vic_req;
    logic [5:0] a_acc_set, a_inv_set, a_vic_set;
    logic [2:0] a_acc_way, a_inv_way;
    logic       a_vic_valid;
    logic [2:0] a_vic_way;
    logic [6:0] a_vic_bits;

    // Instance B: 2 ways, 1 set
    logic       b_acc_valid, b_inv_valid, b_vic_req;
    logic [0:0] b_acc_set, b_inv_set, b_vic_set;
    logic [0:0] b_acc_way, b_inv_way;
    logic       b_vic_valid;
    logic [0:0] b_vic_way;
    logic [0:0] b_vic_bits;

    plru_set_array #(.ASSOC(8), .SETS(64)) u_a (
        .clk(clk), .rst(rst),
        .acc_valid(a_acc_valid), .acc_set(a_acc_set), .acc_way(a_acc_way),
        .inv_valid(a_inv_valid), .inv_set(a_inv_set), .inv_way(a_inv_way),
        .vic_req(a_vic_req), .vic_set(a_vic_set),
        .vic_valid(a_vic_valid), .vic_way(a_vic_way), .vic_bits(a_vic_bits)
    );

    plru_set_array #(.ASSOC(2), .SETS(1)) u_b (
        .clk(clk), .rst(rst),
        .acc_valid(b_acc_valid), .acc_set(b_acc_set), .acc_way(b_acc_way),
        .inv_valid(b_inv_valid), .inv_set(b_inv_set), .inv_way(b_inv_way),
        .vic_req(b_vic_req), .vic_set(b_vic_set),
        .vic_valid(b_vic_valid), .vic_way(b_vic_way), .vic_bits(b_vic_bits)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit armed    = 1'b0;

    // Model state: tree bits per set held as plain integers.
    int ma [64];
    int mb;
    int ea_valid = 0, ea_way = 0, ea_bits = 0;
    int eb_valid = 0, eb_way = 0, eb_bits = 0;

    // Level k of the path for 'way' is heap node (2^k - 1) + (top k bits of way).
    function automatic int m_update(int bits, int way, int lw, bit inv);
        int r;
        r = bits;
        for (int k = 0; k < lw; k++) begin
            int node, b;
            node = (1 << k) - 1 + (way >> (lw - k));
            b    = (way >> (lw - 1 - k)) & 1;
            if (inv) b = b ^ 1;
            if (b != 0) r = r | (1 << node);
            else        r = r & ~(1 << node);
        end
        return r;
    endfunction

    function automatic int m_victim(int bits, int lw);
        int v;
        v = 0;
        for (int k = 0; k < lw; k++) begin
            int node;
            node = (1 << k) - 1 + v;
            v    = 2 * v + ((((bits >> node) & 1) != 0) ? 0 : 1);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply();
        if (rst) begin
            for (int s = 0; s < 64; s++) ma[s] = 0;
            mb = 0;
            ea_valid = 0; ea_way = 0; ea_bits = 0;
            eb_valid = 0; eb_way = 0; eb_bits = 0;
        end else begin
            if (a_inv_valid)
                ma[a_inv_set] = m_update(ma[a_inv_set], int'(a_inv_way), 3, 1'b1);
            if (a_acc_valid && !(a_inv_valid && a_inv_set == a_acc_set))
                ma[a_acc_set] = m_update(ma[a_acc_set], int'(a_acc_way), 3, 1'b0);
            if (a_vic_req) begin
                ea_valid = 1;
                ea_bits  = ma[a_vic_set];
                ea_way   = m_victim(ea_bits, 3);
            end else begin
                ea_valid = 0;
            end
            if (b_inv_valid) mb = m_update(mb, int'(b_inv_way), 1, 1'b1);
            if (b_acc_valid && !b_inv_valid) mb = m_update(mb, int'(b_acc_way), 1, 1'b0);
            if (b_vic_req) begin
                eb_valid = 1;
                eb_bits  = mb;
                eb_way   = m_victim(eb_bits, 1);
            end else begin
                eb_valid = 0;
            end
        end
    endtask

    task automatic clr();
        a_acc_valid = 0; a_inv_valid = 0; a_vic_req = 0;
        b_acc_valid = 0; b_inv_valid = 0; b_vic_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_apply();
        @(negedge clk);
        armed = 1'b1;
        clr();
    endtask

    task automatic query_a(input int s);
        a_vic_req = 1; a_vic_set = 6'(s);
        step();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("a_valid", 32'(a_vic_valid), 32'(ea_valid));
            chk("a_way",   32'(a_vic_way),   32'(ea_way));
            chk("a_bits",  32'(a_vic_bits),  32'(ea_bits));
            chk("b_valid", 32'(b_vic_valid), 32'(eb_valid));
            chk("b_way",   32'(b_vic_way),   32'(eb_way));
            chk("b_bits",  32'(b_vic_bits),  32'(eb_bits));
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        a_acc_set = 0; a_inv_set = 0; a_vic_set = 0; a_acc_way = 0; a_inv_way = 0;
        b_acc_set = 0; b_inv_set = 0; b_vic_set = 0; b_acc_way = 0; b_inv_way = 0;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", 32'(a_vic_valid), 0);
        chk("rst_way",   32'(a_vic_way),   0);
        chk("rst_bits",  32'(a_vic_bits),  0);
        rst = 1'b0;

        // Reset state: victim is the highest way
        query_a(0);
        chk("t1_valid", 32'(a_vic_valid), 1);
        chk("t1_way",   32'(a_vic_way),   7);
        chk("t1_bits",  32'(a_vic_bits),  0);
        step();
        chk("t1_pulse", 32'(a_vic_valid), 0);
        chk("t1_hold",  32'(a_vic_way),   7);

        // Access way 7 then way 3
        a_acc_valid = 1; a_acc_set = 0; a_acc_way = 7; step();
        query_a(0);
        chk("t2a_way", 32'(a_vic_way), 3);
        a_acc_valid = 1; a_acc_set = 0; a_acc_way = 3; step();
        query_a(0);
        chk("t2b_way",  32'(a_vic_way),  5);
        chk("t2b_bits", 32'(a_vic_bits), 32'h56);  // nodes 1,2,4,6

        // Invalidate way 2 makes it the victim
        a_inv_valid = 1; a_inv_set = 0; a_inv_way = 2; step();
        query_a(0);
        chk("t3_way",  32'(a_vic_way),  2);
        chk("t3_bits", 32'(a_vic_bits), 32'h55);   // nodes 0,2,4,6

        // Set/way values without valid have no effect
        a_acc_set = 0; a_acc_way = 0; a_inv_set = 0; a_inv_way = 5; step();
        query_a(0);
        chk("nv_way", 32'(a_vic_way), 2);

        // Forwarding of a same-cycle access into the query
        a_acc_valid = 1; a_acc_set = 5; a_acc_way = 0; query_a(5);
        chk("t4a_way", 32'(a_vic_way), 7);
        a_acc_valid = 1; a_acc_set = 5; a_acc_way = 7; query_a(5);
        chk("t4b_way", 32'(a_vic_way), 3);
        query_a(6);
        chk("t4c_way", 32'(a_vic_way), 7);

        // Same-set access + invalidate: only the invalidate lands
        a_acc_valid = 1; a_acc_set = 9; a_acc_way = 4;
        a_inv_valid = 1; a_inv_set = 9; a_inv_way = 4; step();
        query_a(9);
        chk("t5a_way", 32'(a_vic_way), 4);
        a_acc_valid = 1; a_acc_set = 9; a_acc_way = 3;
        a_inv_valid = 1; a_inv_set = 9; a_inv_way = 4; query_a(9);
        chk("t5b_way",  32'(a_vic_way),  4);
        chk("t5b_bits", 32'(a_vic_bits), 32'h24);  // nodes 2,5

        // Different sets in the same cycle: both land
        a_acc_valid = 1; a_acc_set = 10; a_acc_way = 7;
        a_inv_valid = 1; a_inv_set = 11; a_inv_way = 1; step();
        query_a(10);
        chk("t5c_way", 32'(a_vic_way), 3);
        query_a(11);
        chk("t5d_way", 32'(a_vic_way), 1);

        // Updates, then reset mid-stream with requests asserted
        for (int s = 0; s < 4; s++) begin
            a_acc_valid = 1; a_acc_set = 6'(s); a_acc_way = 3'(s * 3 + 1); step();
        end
        rst = 1'b1;
        a_acc_valid = 1; a_acc_set = 1; a_acc_way = 6;
        a_vic_req = 1; a_vic_set = 1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(a_vic_valid), 0);
        for (int s = 0; s < 4; s++) begin
            query_a(s);
            chk("t6_way", 32'(a_vic_way), 7);
        end
        query_a(9);
        chk("t6_way9", 32'(a_vic_way), 7);

        // Two-way, single-set instance; set index is ignored
        b_vic_req = 1; b_vic_set = 1'($urandom_range(0, 1)); step();
        chk("b_rst_way", 32'(b_vic_way), 1);
        b_acc_valid = 1; b_acc_set = 1'($urandom_range(0, 1)); b_acc_way = 1; step();
        b_vic_req = 1; b_vic_set = 1'($urandom_range(0, 1)); step();
        chk("b_acc1_way", 32'(b_vic_way), 0);
        b_acc_valid = 1; b_acc_way = 0; b_vic_req = 1; step();
        chk("b_acc0_way", 32'(b_vic_way), 1);
        b_inv_valid = 1; b_inv_set = 1; b_inv_way = 0;
        b_acc_valid = 1; b_acc_set = 0; b_acc_way = 0; b_vic_req = 1; step();
        chk("b_inv0_way", 32'(b_vic_way), 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
